// File: rtl/serial_add_defs.sv
// Shared definitions for the bit-serial adder sequencer.
// State encoding; 2'd3 is unused and steers back to idle.
package serial_add_defs;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, the shared datapath of the serial adder.
// Purely combinational; C is carry out, S is sum.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic C,
  output logic S
);

  assign S = x ^ y ^ z;
  assign C = (x & y) | (z & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full_adder swept LSB first
// over WIDTH bits, with valid/ready on operands and result.
module serial_add_ctrl
  import serial_add_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_c;
  logic             fa_s;

  full_adder u_fa (
    .x (a_sh[0]),
    .y (b_sh[0]),
    .z (carry),
    .C (fa_c),
    .S (fa_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (1'b1)
      (state == S_IDLE): if (in_valid) nxt = S_RUN;
      (state == S_RUN):  if (cnt == LAST) nxt = S_DONE;
      (state == S_DONE): if (out_ready) nxt = S_IDLE;
      default:           nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
  end

  // Sum fills from the MSB so it is aligned after the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      sum   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == S_IDLE && in_valid) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      sum   <= {fa_s, sum[WIDTH-1:1]};
      carry <= fa_c;
      if (cnt == LAST) begin
        ovf  <= carry ^ fa_c;
        cout <= fa_c;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
